// File: rtl/alarm_ring_controller_pkg.sv
// -----------------------------------------------------------------------------
// alarm_ring_controller_pkg
// Shared definitions for the alarm ring controller and its second timer.
//   ctrl_state_t : controller state encoding, also consumed by the VGA overlay
//                  (IDLE=0, ARMED=1, RINGING=2, SNOOZE=3).
//   SEC_W        : width of the second counters (ring_cnt, snooze_remain).
//   SCNT_W       : width of the snooze counter.
//   sat_inc_scnt : saturating increment for the snooze counter.
// -----------------------------------------------------------------------------
package alarm_ring_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } ctrl_state_t;

    localparam int SEC_W  = 8;
    localparam int SCNT_W = 4;

    localparam logic [SCNT_W-1:0] SCNT_MAX = '1;

    // The snooze counter sticks at its maximum instead of wrapping to 0.
    function automatic logic [SCNT_W-1:0] sat_inc_scnt(input logic [SCNT_W-1:0] v);
        logic [SCNT_W-1:0] r;
        if (v == SCNT_MAX) begin
            r = v;
        end else begin
            r = v + 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/alarm_ring_controller_sec_timer.sv
// -----------------------------------------------------------------------------
// alarm_sec_timer
// 8-bit loadable second counter. Counts up or down (COUNT_UP) by one on each
// i_tick and flags o_done while the count equals DONE_VAL.
// Priority: i_reset / i_clear (to 0) > i_load > i_tick.
// Ports:
//   i_clk, i_reset   : clock, synchronous active-high reset
//   i_clear          : synchronous clear to 0
//   i_load           : load i_load_val
//   i_load_val[7:0]  : value to load
//   i_tick           : advance the count by one
//   o_count[7:0]     : registered count
//   o_done           : count == DONE_VAL
// -----------------------------------------------------------------------------
module alarm_sec_timer
    import alarm_ring_controller_pkg::*;
#(
    parameter bit               COUNT_UP = 1'b1,
    parameter logic [SEC_W-1:0] DONE_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [SEC_W-1:0] i_load_val,
    input  logic             i_tick,
    output logic [SEC_W-1:0] o_count,
    output logic             o_done
);

    logic [SEC_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_tick) begin
            if (COUNT_UP) begin
                r_count <= r_count + 1'b1;
            end else begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_count = r_count;
    assign o_done  = (r_count == DONE_VAL);

endmodule

// File: rtl/alarm_ring_controller.sv
// -----------------------------------------------------------------------------
// alarm_ring_controller
// Sequences the alarm: arms on alarm_on, rings on the rising edge of
// alarm_match, handles snooze, dismiss and an auto-silence timeout.
// All outputs are registered (one-cycle latency after the causing event).
// Optional feature macro: ALARM_SNOOZE_LIMIT_EN -- when defined, snooze_key
// is ignored in RINGING once snooze_count == MAX_SNOOZE.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   sec_tick            : one-cycle pulse per second
//   alarm_on            : arm switch (level); low forces IDLE
//   alarm_match         : current time == alarm time (level)
//   snooze_key          : one-cycle snooze pulse
//   dismiss_key         : one-cycle dismiss pulse
//   play_sound          : high while RINGING
//   ctrl_state[1:0]     : IDLE=0, ARMED=1, RINGING=2, SNOOZE=3
//   snooze_remain[7:0]  : seconds left in SNOOZE, 0 elsewhere
//   snooze_count[3:0]   : snoozes since last arm/dismiss/timeout (saturating)
// -----------------------------------------------------------------------------
module alarm_ring_controller
    import alarm_ring_controller_pkg::*;
#(
    parameter int SNOOZE_SEC       = 5,
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int MAX_SNOOZE       = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sec_tick,
    input  logic              alarm_on,
    input  logic              alarm_match,
    input  logic              snooze_key,
    input  logic              dismiss_key,
    output logic              play_sound,
    output logic [1:0]        ctrl_state,
    output logic [SEC_W-1:0]  snooze_remain,
    output logic [SCNT_W-1:0] snooze_count
);

    localparam logic [SEC_W-1:0] SNOOZE_LOAD = SEC_W'(SNOOZE_SEC);
    localparam logic [SEC_W-1:0] RING_LAST   = SEC_W'(RING_TIMEOUT_SEC - 1);

    ctrl_state_t       r_state;
    ctrl_state_t       w_next_state;
    logic              r_match_d;
    logic              r_play_sound;
    logic [SCNT_W-1:0] r_snooze_count;
    logic [SCNT_W-1:0] w_next_snooze_count;

    logic              w_match_rise;
    logic              w_snooze_allowed;

    logic              w_ring_clear;
    logic              w_ring_tick;
    logic [SEC_W-1:0]  w_ring_cnt;
    logic              w_ring_done;

    logic              w_snz_clear;
    logic              w_snz_load;
    logic              w_snz_tick;
    logic [SEC_W-1:0]  w_snz_cnt;
    logic              w_snz_done;

    // A match that is already high when we arrive in ARMED never triggers;
    // only a fresh edge does, which also blocks a re-ring in the same second.
    assign w_match_rise = alarm_match & ~r_match_d;

`ifdef ALARM_SNOOZE_LIMIT_EN
    assign w_snooze_allowed = (r_snooze_count != SCNT_W'(MAX_SNOOZE));
`else
    // Unlimited snooze: any in-range cap leaves the key always honoured.
    assign w_snooze_allowed = (MAX_SNOOZE >= 1);
`endif

    // ring_cnt: counts up from 0 while RINGING, done on the last second.
    alarm_sec_timer #(
        .COUNT_UP (1'b1),
        .DONE_VAL (RING_LAST)
    ) u_ring_timer (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_clear    (w_ring_clear),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_tick     (w_ring_tick),
        .o_count    (w_ring_cnt),
        .o_done     (w_ring_done)
    );

    // snooze_remain: loaded with SNOOZE_SEC, counts down, done at 1.
    alarm_sec_timer #(
        .COUNT_UP (1'b0),
        .DONE_VAL (SEC_W'(1))
    ) u_snooze_timer (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_clear    (w_snz_clear),
        .i_load     (w_snz_load),
        .i_load_val (SNOOZE_LOAD),
        .i_tick     (w_snz_tick),
        .o_count    (w_snz_cnt),
        .o_done     (w_snz_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_match_d      <= 1'b0;
            r_play_sound   <= 1'b0;
            r_snooze_count <= '0;
        end else begin
            r_state        <= w_next_state;
            r_match_d      <= alarm_match;
            r_play_sound   <= (w_next_state == ST_RINGING);
            r_snooze_count <= w_next_snooze_count;
        end
    end

    // Within each state a key event outranks sec_tick; a tick arriving with
    // a winning event is simply dropped.
    always_comb begin
        w_next_state        = r_state;
        w_next_snooze_count = r_snooze_count;
        w_ring_clear        = 1'b0;
        w_ring_tick         = 1'b0;
        w_snz_clear         = 1'b0;
        w_snz_load          = 1'b0;
        w_snz_tick          = 1'b0;

        if (!alarm_on) begin
            w_next_state        = ST_IDLE;
            w_next_snooze_count = '0;
            w_ring_clear        = 1'b1;
            w_snz_clear         = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_ARMED;
                end
                ST_ARMED: begin
                    if (w_match_rise) begin
                        w_next_state = ST_RINGING;
                        w_ring_clear = 1'b1;
                    end
                end
                ST_RINGING: begin
                    if (dismiss_key) begin
                        w_next_state        = ST_ARMED;
                        w_next_snooze_count = '0;
                        w_ring_clear        = 1'b1;
                    end else if (snooze_key && w_snooze_allowed) begin
                        w_next_state        = ST_SNOOZE;
                        w_next_snooze_count = sat_inc_scnt(r_snooze_count);
                        w_snz_load          = 1'b1;
                    end else if (sec_tick) begin
                        if (w_ring_done) begin
                            w_next_state        = ST_ARMED;
                            w_next_snooze_count = '0;
                            w_ring_clear        = 1'b1;
                        end else begin
                            // Guard keeps the counter from wrapping if the
                            // timeout is ever configured past its range.
                            w_ring_tick = (w_ring_cnt != '1);
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (dismiss_key) begin
                        w_next_state        = ST_ARMED;
                        w_next_snooze_count = '0;
                        w_snz_clear         = 1'b1;
                    end else if (sec_tick) begin
                        if (w_snz_done) begin
                            w_next_state = ST_RINGING;
                            w_ring_clear = 1'b1;
                            w_snz_clear  = 1'b1;
                        end else begin
                            w_snz_tick = 1'b1;
                        end
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    assign play_sound    = r_play_sound;
    assign ctrl_state    = r_state;
    assign snooze_remain = w_snz_cnt;
    assign snooze_count  = r_snooze_count;

endmodule

// File: tb/tb_alarm_ring_controller.sv
module tb_alarm_ring_controller;

    localparam int SNOOZE_SEC       = 5;
    localparam int RING_TIMEOUT_SEC = 3;
    localparam int MAX_SNOOZE       = 2;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sec_tick = 1'b0;
    logic       alarm_on = 1'b0;
    logic       alarm_match = 1'b0;
    logic       snooze_key = 1'b0;
    logic       dismiss_key = 1'b0;
    logic       play_sound;
    logic [1:0] ctrl_state;
    logic [7:0] snooze_remain;
    logic [3:0] snooze_count;

    always #5 clk = ~clk;

    alarm_ring_controller #(
        .SNOOZE_SEC       (SNOOZE_SEC),
        .RING_TIMEOUT_SEC (RING_TIMEOUT_SEC),
        .MAX_SNOOZE       (MAX_SNOOZE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sec_tick      (sec_tick),
        .alarm_on      (alarm_on),
        .alarm_match   (alarm_match),
        .snooze_key    (snooze_key),
        .dismiss_key   (dismiss_key),
        .play_sound    (play_sound),
        .ctrl_state    (ctrl_state),
        .snooze_remain (snooze_remain),
        .snooze_count  (snooze_count)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Behavioural view: mode name, seconds rung, seconds of snooze left,
    // number of snoozes taken. Updated once per clock from the inputs
    // presented for that clock.
    localparam int M_IDLE = 0, M_ARMED = 1, M_RINGING = 2, M_SNOOZE = 3;
    int m_state = M_IDLE;
    int m_rung  = 0;
    int m_snz   = 0;
    int m_cnt   = 0;
    bit m_prev_match = 1'b0;

    function automatic bit model_snooze_ok();
`ifdef ALARM_SNOOZE_LIMIT_EN
        return m_cnt < MAX_SNOOZE;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_step();
        bit rise;
        rise = alarm_match && !m_prev_match;
        if (reset) begin
            m_state = M_IDLE; m_rung = 0; m_snz = 0; m_cnt = 0; m_prev_match = 0;
            return;
        end
        m_prev_match = alarm_match;
        if (!alarm_on) begin
            m_state = M_IDLE; m_rung = 0; m_snz = 0; m_cnt = 0;
            return;
        end
        case (m_state)
            M_IDLE: m_state = M_ARMED;
            M_ARMED: if (rise) begin m_state = M_RINGING; m_rung = 0; end
            M_RINGING: begin
                if (dismiss_key) begin
                    m_state = M_ARMED; m_cnt = 0;
                end else if (snooze_key && model_snooze_ok()) begin
                    m_state = M_SNOOZE; m_snz = SNOOZE_SEC;
                    m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
                end else if (sec_tick) begin
                    m_rung++;
                    if (m_rung >= RING_TIMEOUT_SEC) begin
                        m_state = M_ARMED; m_cnt = 0; m_rung = 0;
                    end
                end
            end
            default: begin // snooze
                if (dismiss_key) begin
                    m_state = M_ARMED; m_cnt = 0; m_snz = 0;
                end else if (sec_tick) begin
                    m_snz--;
                    if (m_snz == 0) begin m_state = M_RINGING; m_rung = 0; end
                end
            end
        endcase
    endtask

    // ---------------- driver ----------------
    int tick_div = 0;

    // One clock: place sec_tick, advance the model, sample after the edge.
    task automatic cycle();
        @(negedge clk);
        sec_tick = (tick_div == 9);
        tick_div = (tick_div == 9) ? 0 : tick_div + 1;
        model_step();
        @(posedge clk);
        #1;
        check_eq("ctrl_state",    32'(ctrl_state),    32'(m_state));
        check_eq("play_sound",    32'(play_sound),    32'(m_state == M_RINGING));
        check_eq("snooze_remain", 32'(snooze_remain), 32'(m_snz));
        check_eq("snooze_count",  32'(snooze_count),  32'(m_cnt));
        snooze_key  = 1'b0;
        dismiss_key = 1'b0;
    endtask

    task automatic wait_state(input int s, input int budget, input string tag);
        int n;
        n = 0;
        while (m_state != s && n < budget) begin
            cycle();
            n++;
        end
        check_eq(tag, 32'(ctrl_state), 32'(s));
    endtask

    task automatic ring_up(input string tag);
        alarm_match = 1'b0;
        cycle();
        alarm_match = 1'b1;
        cycle();
        check_eq(tag, 32'(ctrl_state), 32'd2);
        alarm_match = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        cycle();
        cycle();
        check_eq("reset_state", 32'(ctrl_state), 32'd0);
        check_eq("reset_sound", 32'(play_sound), 32'd0);
        reset = 1'b0;

        // 1. arm then ring on the match edge
        alarm_on = 1'b1;
        cycle();
        check_eq("armed", 32'(ctrl_state), 32'd1);
        ring_up("t1_ring");
        check_eq("t1_sound", 32'(play_sound), 32'd1);

        // 2. snooze countdown and return to ringing
        snooze_key = 1'b1;
        cycle();
        check_eq("t2_snooze", 32'(ctrl_state), 32'd3);
        check_eq("t2_remain", 32'(snooze_remain), 32'd5);
        wait_state(M_RINGING, 80, "t2_back_ring");
        check_eq("t2_count", 32'(snooze_count), 32'd1);

        // 3. timeout with match held high: no re-ring
        alarm_match = 1'b1;
        wait_state(M_ARMED, 60, "t3_timeout");
        check_eq("t3_sound", 32'(play_sound), 32'd0);
        for (int i = 0; i < 30; i++) cycle();
        check_eq("t3_no_rering", 32'(ctrl_state), 32'd1);

        // 4. snooze and dismiss together: dismiss wins
        ring_up("t4_ring");
        snooze_key = 1'b1;
        dismiss_key = 1'b1;
        cycle();
        check_eq("t4_state",  32'(ctrl_state),    32'd1);
        check_eq("t4_count",  32'(snooze_count),  32'd0);
        check_eq("t4_remain", 32'(snooze_remain), 32'd0);

        // 5. snooze cap
        ring_up("t5_ring");
        snooze_key = 1'b1; cycle();
        wait_state(M_RINGING, 80, "t5_back1");
        snooze_key = 1'b1; cycle();
        wait_state(M_RINGING, 80, "t5_back2");
        check_eq("t5_count2", 32'(snooze_count), 32'd2);
        snooze_key = 1'b1; cycle();
`ifdef ALARM_SNOOZE_LIMIT_EN
        check_eq("t5_capped_state", 32'(ctrl_state),   32'd2);
        check_eq("t5_capped_count", 32'(snooze_count), 32'd2);
        dismiss_key = 1'b1; cycle();
`else
        check_eq("t5_third_state", 32'(ctrl_state),   32'd3);
        check_eq("t5_third_count", 32'(snooze_count), 32'd3);
        // keep snoozing to reach saturation at 15
        for (int i = 0; i < 13; i++) begin
            wait_state(M_RINGING, 80, "sat_back");
            snooze_key = 1'b1;
            cycle();
        end
        check_eq("sat_count", 32'(snooze_count), 32'd15);
        dismiss_key = 1'b1; cycle();
`endif
        check_eq("t5_dismissed", 32'(ctrl_state), 32'd1);

        // 6. alarm_on drop mid-snooze, then reset mid-ring
        ring_up("t6_ring");
        snooze_key = 1'b1; cycle();
        begin
            int n;
            n = 0;
            while (m_snz != 3 && n < 60) begin cycle(); n++; end
        end
        check_eq("t6_remain3", 32'(snooze_remain), 32'd3);
        alarm_on = 1'b0;
        cycle();
        check_eq("t6_idle",   32'(ctrl_state),    32'd0);
        check_eq("t6_remain", 32'(snooze_remain), 32'd0);
        check_eq("t6_count",  32'(snooze_count),  32'd0);
        alarm_on = 1'b1;
        cycle();
        ring_up("t6_ring2");
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_eq("t6_rst_state", 32'(ctrl_state), 32'd0);
        check_eq("t6_rst_sound", 32'(play_sound), 32'd0);

        // random phase
        for (int i = 0; i < 3000; i++) begin
            if (tick_div == 0) alarm_match = ($urandom_range(0, 3) == 0);
            if (alarm_on) alarm_on = ($urandom_range(0, 299) != 0);
            else          alarm_on = ($urandom_range(0, 4) == 0);
            snooze_key  = ($urandom_range(0, 24) == 0);
            dismiss_key = ($urandom_range(0, 59) == 0);
            reset       = ($urandom_range(0, 999) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
